// File: rtl/wishbone_command_initiator_if.sv
// Client command/response handshake plus Wishbone B4 pipelined initiator signals.
// master = initiator block, slave = client/target environment.
interface wishbone_command_initiator_if #(
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 8,
  parameter int Granularity  = 8
);
  localparam int SELWidth = DataWidth / Granularity;

  logic                    CMD_VALID;
  logic                    CMD_READY;
  logic                    CMD_WE;
  logic [AddressWidth-1:0] CMD_ADDR;
  logic [DataWidth-1:0]    CMD_DATA;
  logic [SELWidth-1:0]     CMD_SEL;

  logic                    RSP_VALID;
  logic                    RSP_READY;
  logic [DataWidth-1:0]    RSP_DATA;
  logic                    RSP_ERR;
  logic                    RSP_RTY;
  logic                    SPURIOUS;

  logic                    CYC;
  logic                    STB;
  logic                    WE;
  logic [AddressWidth-1:0] ADDR;
  logic [DataWidth-1:0]    DAT_ToTarget;
  logic [SELWidth-1:0]     SEL;
  logic [DataWidth-1:0]    DAT_ToInitiator;
  logic                    ACK;
  logic                    ERR;
  logic                    RTY;
  logic                    STALL;

  modport master (
    input  CMD_VALID, CMD_WE, CMD_ADDR, CMD_DATA, CMD_SEL, RSP_READY,
           DAT_ToInitiator, ACK, ERR, RTY, STALL,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, RSP_RTY, SPURIOUS,
           CYC, STB, WE, ADDR, DAT_ToTarget, SEL
  );

  modport slave (
    output CMD_VALID, CMD_WE, CMD_ADDR, CMD_DATA, CMD_SEL, RSP_READY,
           DAT_ToInitiator, ACK, ERR, RTY, STALL,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, RSP_RTY, SPURIOUS,
           CYC, STB, WE, ADDR, DAT_ToTarget, SEL
  );
endinterface

// File: rtl/wishbone_command_initiator.sv
// Wishbone B4 pipelined initiator: client commands become STB beats under one CYC, terminations return in order.
// Latency: accept -> STB 1 cycle; backpressure: CMD_READY low when MaxOutstanding in flight or the STB beat is stalled.
module wishbone_command_initiator #(
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 8,
  parameter int Granularity    = 8,
  parameter int MaxOutstanding = 4
) (
  input logic CLK,
  input logic RST,
  wishbone_command_initiator_if.master bus
);
  localparam int SELWidth = DataWidth / Granularity;
  localparam int PtrWidth = $clog2(MaxOutstanding);
  localparam int CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0] MaxCount = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] One      = CntWidth'(1);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 err;
    logic                 rty;
  } rsp_t;

  logic [CntWidth-1:0]     inflight, inflight_nxt;
  logic [CntWidth-1:0]     pending, pending_nxt;
  logic                    stb_q, stb_nxt, cyc_q, we_q, spurious_q;
  logic [AddressWidth-1:0] addr_q;
  logic [DataWidth-1:0]    dat_q;
  logic [SELWidth-1:0]     sel_q;
  logic                    cmd_ready, accept, handoff, term_any, term_ok, pop, rsp_vld;

  // Extra pointer bit separates full from empty.
  rsp_t                    rsp_mem [MaxOutstanding];
  logic [CntWidth-1:0]     wr_ptr, rd_ptr;
  rsp_t                    rsp_head;

  assign cmd_ready = RST && (inflight < MaxCount) && (!stb_q || !bus.STALL);
  assign accept    = bus.CMD_VALID && cmd_ready;
  assign handoff   = stb_q && !bus.STALL;
  assign term_any  = bus.ACK || bus.ERR || bus.RTY;
  // Presented beats are already counted in pending, so a zero-wait answer is covered.
  assign term_ok   = term_any && cyc_q && (pending != '0);
  assign rsp_vld   = (wr_ptr != rd_ptr);
  assign pop       = rsp_vld && bus.RSP_READY;
  assign rsp_head  = rsp_mem[rd_ptr[PtrWidth-1:0]];

  always_comb begin
    stb_nxt = stb_q;
    if (accept)       stb_nxt = 1'b1;
    else if (handoff) stb_nxt = 1'b0;

    inflight_nxt = inflight;
    if (accept && !pop)      inflight_nxt = inflight + One;
    else if (!accept && pop) inflight_nxt = inflight - One;

    pending_nxt = pending;
    if (accept && !term_ok)      pending_nxt = pending + One;
    else if (!accept && term_ok) pending_nxt = pending - One;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      spurious_q <= 1'b0;
      inflight   <= '0;
      pending    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      stb_q      <= stb_nxt;
      cyc_q      <= stb_nxt || (pending_nxt != '0);
      inflight   <= inflight_nxt;
      pending    <= pending_nxt;
      spurious_q <= term_any && !term_ok;
      if (accept) begin
        we_q   <= bus.CMD_WE;
        addr_q <= bus.CMD_ADDR;
        dat_q  <= bus.CMD_DATA;
        sel_q  <= bus.CMD_SEL;
      end
      if (term_ok) wr_ptr <= wr_ptr + One;
      if (pop)     rd_ptr <= rd_ptr + One;
    end
  end

  // ACK outranks ERR, which outranks RTY.
  always_ff @(posedge CLK) begin
    if (term_ok) begin
      rsp_mem[wr_ptr[PtrWidth-1:0]] <= '{data: bus.DAT_ToInitiator,
                                         err:  !bus.ACK && bus.ERR,
                                         rty:  !bus.ACK && !bus.ERR && bus.RTY};
    end
  end

  assign bus.CMD_READY    = cmd_ready;
  assign bus.RSP_VALID    = rsp_vld;
  assign bus.RSP_DATA     = rsp_head.data;
  assign bus.RSP_ERR      = rsp_head.err;
  assign bus.RSP_RTY      = rsp_head.rty;
  assign bus.SPURIOUS     = spurious_q;
  assign bus.CYC          = cyc_q;
  assign bus.STB          = stb_q;
  assign bus.WE           = we_q;
  assign bus.ADDR         = addr_q;
  assign bus.DAT_ToTarget = dat_q;
  assign bus.SEL          = sel_q;
endmodule
